aes128_stream_ctrl: RTL and testbench
=====================================

# aes128_stream_ctrl

Message-level sequencer for the `aes128` core. It accepts one message descriptor: mode, direction, key, IV, segment length and block count. It then streams 128-bit blocks into the core over a valid/ready input and returns the results over a valid/ready output. It owns the core's `cipher_en`/`decipher_en`/`chain_en` sequencing so that upstream logic never handles the core's chaining protocol directly.

## Interface
- `MAX_BLOCKS`, default 65535: largest legal block count per message; `cnt` width is `$clog2(MAX_BLOCKS+1)`.
- `TIMEOUT_CYC`, default 1023: watchdog limit in cycles, used only with `AES_CTRL_TIMEOUT_EN`.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `desc_valid` in 1: descriptor offered.
- `desc_ready` out 1: controller idle; descriptor accepted on `desc_valid & desc_ready`.
- `desc_decipher` in 1: 0 = cipher, 1 = decipher.
- `desc_mode` in 4: 0 ECB, 1 CBC, 2 CFB, 3 OFB, 4 CTR.
- `desc_key` in 128: key.
- `desc_iv` in 128: initial vector.
- `desc_seglen` in 16: segment length, passed through to the core.
- `desc_nblk` in cnt: number of blocks in the message.
- `in_valid` in 1, `in_ready` out 1, `in_data` in 128: input block stream.
- `out_valid` out 1, `out_ready` in 1, `out_data` out 128: result stream.
- `out_last` out 1: asserted with the final block of the message.
- `err` out 1: one-cycle pulse on a rejected descriptor or a timeout.
- `core_cipher_en`, `core_decipher_en`, `core_chain_en` out 1: core controls.
- `core_data_in`, `core_key`, `core_init_vector` out 128: core data inputs.
- `core_mode` out 4, `core_segment_len` out 16: core configuration.
- `core_data_out` in 128, `core_ready` in 1: core results.

## Operation
- **Descriptor capture:** registered in full on acceptance. The `core_key`, `core_mode`, `core_init_vector` and `core_segment_len` outputs are driven from these registers and stay stable for the whole message.
- **Rejection:** a descriptor with `desc_mode > 4` or `desc_nblk == 0` is accepted but rejected. `err` pulses, the FSM stays in IDLE and nothing is sent to the core.
- **States:**
  - IDLE: `desc_ready = 1`. A legal descriptor moves the FSM to CHAIN_RST.
  - CHAIN_RST: exactly one cycle with `core_chain_en = 0`, which clears the core's chaining state. Then WAIT_IN.
  - WAIT_IN: `in_ready = 1`. On input acceptance, capture `in_data` into `core_data_in`, then ISSUE.
  - ISSUE: exactly one cycle with `core_cipher_en` or `core_decipher_en = 1`, selected by `desc_decipher`. Then BUSY.
  - BUSY: wait for a rising edge of `core_ready` (registered previous value). On the edge, capture `core_data_out` into the output register, set `out_valid`, then OUT_HOLD.
  - OUT_HOLD: wait for `out_valid & out_ready`. Decrement the remaining-block counter. If it reaches 0, go to IDLE; otherwise go to WAIT_IN.
- **`core_chain_en`:** 1 in every state from WAIT_IN through OUT_HOLD. 0 in IDLE and CHAIN_RST.
- **`out_last`:** 1 while `out_valid` is 1 and the remaining count is 1.
- **Blocks in flight:** only one block is ever inside the core. `in_ready` is 0 outside WAIT_IN.

## Timing
- **Reset values:** every output is 0. The FSM is in IDLE. All registers, including the data registers, are 0. Reset asserted mid-message aborts the message immediately; no partial output is produced.
- **Descriptor to first `in_ready`:** descriptor accepted at cycle N; CHAIN_RST at N+1; `in_ready` at N+2.
- **Input to core start:** input accepted at cycle M; core enable high at M+1, for exactly one cycle.
- **Core result to output:** `core_ready` rises at cycle R; `out_valid` at R+1. Zero-wait result return.
- **Back-to-back blocks:** with `out_ready` held at 1, the next `in_ready` comes one cycle after the output handshake.
- **Backpressure:** while `out_valid` is 1 and `out_ready` is 0, `out_data` and `out_last` stay stable.
- **Stray `core_ready`:** a `core_ready` edge outside BUSY is ignored.
- **Simultaneous events:** `desc_valid` is ignored outside IDLE. In the cycle of the last output handshake, `desc_ready` is still 0; it rises the next cycle.

## Configuration
- **`AES_CTRL_TIMEOUT_EN` defined:**
  - A counter runs in BUSY.
  - After `TIMEOUT_CYC` cycles without a `core_ready` edge, `err` pulses, the message is aborted and the FSM returns to IDLE with `core_chain_en = 0`.
  - The counter clears on entry to BUSY.
- **`AES_CTRL_TIMEOUT_EN` undefined:** no counter exists, and BUSY waits indefinitely.

## Structure
- **Shared package `aes128_pkg`:** `aes_mode_e` (ECB = 0 … CTR = 4), `ctrl_state_e`, and the constant `AES_BLK_W = 128`.
- **Sub-module:** `aes128_stream_ctrl` holds the FSM and registers. The `aes128` core itself is instantiated at the next level up, not inside this block.

## Test plan
- **OFB cipher, 4 blocks:** `key = 2b7e151628aed2a6abf7158809cf4f3c`, `iv = 000102030405060708090a0b0c0d0e0f`, input `6bc1bee22e409f96e93d7e117393172a` … → outputs `3b3fd92eb72dad20333449f8e83cfb4a`, `7789508d16918f03f53c52dac54ed825`, `9740051e9c5fecf64344f7a82260edcc`, `304c6528f659c77866a510d9c1d6ae5e`; `out_last` only on the 4th.
- **OFB decipher, same vectors, `seglen = 3`:** recovers the plaintexts. Exactly one `core_chain_en = 0` cycle precedes the first block.
- **Backpressure:** `out_ready = 0` for 20 cycles on block 2 → `out_data` stable, `in_ready = 0`, no second core enable pulse.
- **Illegal descriptors:** `desc_mode = 7`, or `desc_nblk = 0` → one `err` pulse, no core enable, `desc_ready` stays 1.
- **Reset mid-message:** `rst` pulsed during BUSY of block 2 → all outputs 0. A new descriptor afterwards yields correct block-1 results.
- **Timeout (macro defined, `TIMEOUT_CYC = 15`):** stubbed core that never raises `ready` → `err` 16 cycles after entering BUSY, then IDLE.

Source files
------------

// File: rtl/aes128_pkg.sv
// rtl/aes128_pkg.sv - shared types and constants for the aes128 stream controller
package aes128_pkg;

    localparam int AES_BLK_W = 128;

    typedef enum logic [3:0] {
        MODE_ECB = 4'd0,
        MODE_CBC = 4'd1,
        MODE_CFB = 4'd2,
        MODE_OFB = 4'd3,
        MODE_CTR = 4'd4
    } aes_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHAIN_RST,
        ST_WAIT_IN,
        ST_ISSUE,
        ST_BUSY,
        ST_OUT_HOLD
    } ctrl_state_e;

    function automatic logic mode_legal(input logic [3:0] mode);
        return mode <= 4'(MODE_CTR);
    endfunction

endpackage

// File: rtl/aes128_stream_ctrl.sv
// rtl/aes128_stream_ctrl.sv - message sequencer for the aes128 core; AES_CTRL_TIMEOUT_EN adds a BUSY watchdog
module aes128_stream_ctrl
    import aes128_pkg::*;
#(
    parameter int MAX_BLOCKS  = 65535,
    parameter int TIMEOUT_CYC = 1023,
    localparam int CNT_W = $clog2(MAX_BLOCKS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 desc_valid,
    output logic                 desc_ready,
    input  logic                 desc_decipher,
    input  logic [3:0]           desc_mode,
    input  logic [AES_BLK_W-1:0] desc_key,
    input  logic [AES_BLK_W-1:0] desc_iv,
    input  logic [15:0]          desc_seglen,
    input  logic [CNT_W-1:0]     desc_nblk,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AES_BLK_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AES_BLK_W-1:0] out_data,
    output logic                 out_last,
    output logic                 err,
    output logic                 core_cipher_en,
    output logic                 core_decipher_en,
    output logic                 core_chain_en,
    output logic [AES_BLK_W-1:0] core_data_in,
    output logic [AES_BLK_W-1:0] core_key,
    output logic [AES_BLK_W-1:0] core_init_vector,
    output logic [3:0]           core_mode,
    output logic [15:0]          core_segment_len,
    input  logic [AES_BLK_W-1:0] core_data_out,
    input  logic                 core_ready
);

    if (TIMEOUT_CYC < 1 || MAX_BLOCKS < 1) begin : g_param_check
        $error("aes128_stream_ctrl: TIMEOUT_CYC and MAX_BLOCKS must be >= 1");
    end

    ctrl_state_e      state, state_nx;
    logic             dec_r;
    aes_mode_e        mode_r;
    logic [CNT_W-1:0] remaining;
    logic             core_ready_q;
    logic             desc_hs, desc_bad, in_hs, out_hs, rdy_rise, timeout_hit;

    assign desc_hs  = desc_valid & desc_ready;
    assign desc_bad = !mode_legal(desc_mode) || (desc_nblk == '0);
    assign in_hs    = in_valid & in_ready;
    assign out_hs   = out_valid & out_ready;
    assign rdy_rise = core_ready & ~core_ready_q;

`ifdef AES_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == ST_ISSUE) begin
            to_cnt <= '0;
        end else if (state == ST_BUSY) begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end

    assign timeout_hit = (state == ST_BUSY) && (to_cnt == TO_W'(TIMEOUT_CYC));
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (desc_hs && !desc_bad) state_nx = ST_CHAIN_RST;
            ST_CHAIN_RST: state_nx = ST_WAIT_IN;
            ST_WAIT_IN:   if (in_hs) state_nx = ST_ISSUE;
            ST_ISSUE:     state_nx = ST_BUSY;
            ST_BUSY: begin
                if (rdy_rise) begin
                    state_nx = ST_OUT_HOLD;
                end else if (timeout_hit) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_OUT_HOLD: begin
                if (out_hs) begin
                    state_nx = (remaining == CNT_W'(1)) ? ST_IDLE : ST_WAIT_IN;
                end
            end
            default:      state_nx = ST_IDLE;
        endcase
    end

    // desc_ready is gated by rst so every output reads 0 while reset is held
    assign desc_ready       = (state == ST_IDLE) & ~rst;
    assign in_ready         = (state == ST_WAIT_IN);
    assign out_valid        = (state == ST_OUT_HOLD);
    assign out_last         = out_valid & (remaining == CNT_W'(1));
    assign core_chain_en    = (state == ST_WAIT_IN) || (state == ST_ISSUE) ||
                              (state == ST_BUSY) || (state == ST_OUT_HOLD);
    assign core_cipher_en   = (state == ST_ISSUE) & ~dec_r;
    assign core_decipher_en = (state == ST_ISSUE) & dec_r;
    assign core_mode        = mode_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            core_ready_q     <= 1'b0;
            dec_r            <= 1'b0;
            mode_r           <= MODE_ECB;
            core_key         <= '0;
            core_init_vector <= '0;
            core_segment_len <= '0;
            remaining        <= '0;
            core_data_in     <= '0;
            out_data         <= '0;
            err              <= 1'b0;
        end else begin
            state        <= state_nx;
            core_ready_q <= core_ready;
            err          <= (desc_hs && desc_bad) || (timeout_hit && !rdy_rise);
            // rejected descriptors leave the core configuration untouched
            if (desc_hs && !desc_bad) begin
                dec_r            <= desc_decipher;
                mode_r           <= aes_mode_e'(desc_mode);
                core_key         <= desc_key;
                core_init_vector <= desc_iv;
                core_segment_len <= desc_seglen;
                remaining        <= desc_nblk;
            end
            if (in_hs) begin
                core_data_in <= in_data;
            end
            if (state == ST_BUSY && rdy_rise) begin
                out_data <= core_data_out;
            end
            if (out_hs) begin
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_aes128_stream_ctrl.sv
// tb/tb_aes128_stream_ctrl.sv - scoreboard bench for aes128_stream_ctrl with a keystream core stub
module tb_aes128_stream_ctrl;
    import aes128_pkg::*;

    localparam logic [127:0] NIST_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] NIST_IV  = 128'h000102030405060708090a0b0c0d0e0f;

    logic         clk = 1'b0;
    logic         rst;
    logic         desc_valid, desc_ready, desc_decipher;
    logic [3:0]   desc_mode;
    logic [127:0] desc_key, desc_iv;
    logic [15:0]  desc_seglen, desc_nblk;
    logic         in_valid, in_ready;
    logic [127:0] in_data;
    logic         out_valid, out_ready, out_last, err;
    logic [127:0] out_data;
    logic         core_cipher_en, core_decipher_en, core_chain_en;
    logic [127:0] core_data_in, core_key, core_init_vector, core_data_out;
    logic [3:0]   core_mode;
    logic [15:0]  core_segment_len;
    logic         core_ready;

    aes128_stream_ctrl #(.MAX_BLOCKS(65535), .TIMEOUT_CYC(15)) dut (
        .clk(clk), .rst(rst),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_decipher(desc_decipher),
        .desc_mode(desc_mode), .desc_key(desc_key), .desc_iv(desc_iv),
        .desc_seglen(desc_seglen), .desc_nblk(desc_nblk),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .err(err),
        .core_cipher_en(core_cipher_en), .core_decipher_en(core_decipher_en),
        .core_chain_en(core_chain_en), .core_data_in(core_data_in), .core_key(core_key),
        .core_init_vector(core_init_vector), .core_mode(core_mode),
        .core_segment_len(core_segment_len), .core_data_out(core_data_out),
        .core_ready(core_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } exp_t;

    logic [127:0] in_q[$];
    exp_t         exp_q[$];
    logic [127:0] pt[4], ct[4], ks_tab[4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    // Core behaviour: result = data ^ keystream(config, block index since chain reset)
    function automatic logic [127:0] ks_fn(input logic [127:0] key, input logic [127:0] iv,
                                           input logic [3:0] mode, input logic [15:0] seglen,
                                           input logic dec, input int idx);
        if (mode == 4'd3 && key == NIST_KEY && iv == NIST_IV && idx < 4) return ks_tab[idx];
        return key ^ {iv[119:0], iv[127:120]} ^ {mode, 11'h0, dec, seglen, 32'(idx), 64'h0};
    endfunction

    // core stub
    bit           stub_dead = 0;
    int           stub_lat_fix = -1;
    int           stub_issued = 0;
    int           stub_issue_cyc = 0;
    int           chain_idx = 0;
    bit           stub_busy = 0;
    int           stub_lat = 0;
    logic [127:0] stub_res;
    int           rise_cyc = -10;
    int           in_hs_cyc = -10;

    initial begin
        core_ready    = 1'b0;
        core_data_out = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                core_ready = 1'b0;
                stub_busy  = 0;
                chain_idx  = 0;
            end else begin
                if (!core_chain_en) chain_idx = 0;
                if (stub_busy) begin
                    if (stub_lat == 0) begin
                        core_ready    = 1'b1;
                        core_data_out = stub_res;
                        stub_busy     = 0;
                        rise_cyc      = cyc;
                    end else begin
                        stub_lat--;
                    end
                end
                if (core_cipher_en || core_decipher_en) begin
                    chk("en_exclusive", 128'(core_cipher_en & core_decipher_en), 128'(0));
                    chk("chain_en_at_issue", 128'(core_chain_en), 128'(1));
                    chk("in_to_start", 128'(cyc), 128'(in_hs_cyc + 1));
                    stub_res = core_data_in ^ ks_fn(core_key, core_init_vector, core_mode,
                                                    core_segment_len, core_decipher_en, chain_idx);
                    chain_idx++;
                    stub_issued++;
                    stub_issue_cyc = cyc;
                    core_ready = 1'b0;
                    stub_busy  = !stub_dead;
                    stub_lat   = (stub_lat_fix >= 0) ? stub_lat_fix : int'($urandom_range(0, 3));
                end
            end
        end
    end

    // input driver
    bit in_pending = 0;
    initial begin
        in_valid = 1'b0;
        in_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_pending = 0;
                in_valid   = 1'b0;
            end else begin
                if (in_pending && in_q.size() > 0) void'(in_q.pop_front());
                in_pending = 0;
                if (in_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_data  = in_q[0];
                end else begin
                    in_valid = 1'b0;
                end
                if (in_valid && in_ready) begin
                    in_pending = 1;
                    in_hs_cyc  = cyc;
                end
            end
        end
    end

    // output monitor
    bit           bp_en = 0;
    int           bp_cnt = 0;
    int           out_idx = 0;
    logic         prev_hold = 0, prev_ov = 0, held_l = 0;
    logic [127:0] held_d = '0;
    bit           chk_in_next = 0, chk_dr_next = 0;
    initial begin
        exp_t e;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                out_ready   = 1'b0;
                out_idx     = 0;
                prev_hold   = 0;
                prev_ov     = 0;
                chk_in_next = 0;
                chk_dr_next = 0;
            end else begin
                if (chk_in_next) chk("b2b_in_ready", 128'(in_ready), 128'(1));
                if (chk_dr_next) chk("desc_ready_after_last", 128'(desc_ready), 128'(1));
                chk_in_next = 0;
                chk_dr_next = 0;
                if (prev_hold) begin
                    chk("hold_valid", 128'(out_valid), 128'(1));
                    chk("hold_data", out_data, held_d);
                    chk("hold_last", 128'(out_last), 128'(held_l));
                end
                if (out_valid && !prev_ov) chk("ready_to_valid", 128'(cyc), 128'(rise_cyc + 1));
                if (bp_en && out_valid && out_idx == 1 && bp_cnt < 20) begin
                    out_ready = 1'b0;
                    bp_cnt++;
                    chk("bp_in_ready", 128'(in_ready), 128'(0));
                    chk("bp_no_enable", 128'(core_cipher_en | core_decipher_en), 128'(0));
                end else begin
                    out_ready = bp_en ? 1'b1 : ($urandom_range(0, 3) != 0);
                end
                prev_hold = out_valid && !out_ready;
                held_d    = out_data;
                held_l    = out_last;
                prev_ov   = out_valid;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_output: got %h expected none", out_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_data", out_data, e.data);
                        chk("out_last", 128'(out_last), 128'(e.last));
                        chk("desc_ready_in_last_hs", 128'(desc_ready), 128'(0));
                        if (e.last) begin
                            out_idx     = 0;
                            chk_dr_next = 1;
                        end else begin
                            out_idx++;
                            chk_in_next = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic send_desc(input logic dec, input logic [3:0] mode, input logic [127:0] key,
                             input logic [127:0] iv, input logic [15:0] seglen,
                             input logic [15:0] nblk);
        int t = 0;
        @(negedge clk);
        while (!desc_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!desc_ready) begin
            fail_now("desc_ready_wait");
            return;
        end
        desc_valid    = 1'b1;
        desc_decipher = dec;
        desc_mode     = mode;
        desc_key      = key;
        desc_iv       = iv;
        desc_seglen   = seglen;
        desc_nblk     = nblk;
        @(negedge clk);
        desc_valid = 1'b0;
        if (mode <= 4'd4 && nblk != 16'd0) begin
            chk("chain_rst_chain_en", 128'(core_chain_en), 128'(0));
            chk("chain_rst_in_ready", 128'(in_ready), 128'(0));
            chk("chain_rst_desc_ready", 128'(desc_ready), 128'(0));
            @(negedge clk);
            chk("first_in_ready", 128'(in_ready), 128'(1));
            chk("wait_in_chain_en", 128'(core_chain_en), 128'(1));
            chk("core_key", core_key, key);
            chk("core_iv", core_init_vector, iv);
            chk("core_cfg", 128'({core_mode, core_segment_len}), 128'({mode, seglen}));
        end else begin
            chk("reject_err", 128'(err), 128'(1));
            chk("reject_desc_ready", 128'(desc_ready), 128'(1));
            chk("reject_chain_en", 128'(core_chain_en), 128'(0));
            @(negedge clk);
            chk("reject_err_pulse", 128'(err), 128'(0));
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_q.size() != 0 || !desc_ready) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) fail_now("wait_done");
    endtask

    task automatic rand_msg(input int n);
        logic         dec;
        logic [3:0]   mode;
        logic [15:0]  seglen;
        logic [127:0] key, iv, d;
        exp_t         e;
        dec    = 1'($urandom_range(0, 1));
        mode   = 4'($urandom_range(0, 4));
        seglen = 16'($urandom);
        key    = {$urandom, $urandom, $urandom, $urandom};
        iv     = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < n; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            in_q.push_back(d);
            e.data = d ^ ks_fn(key, iv, mode, seglen, dec, i);
            e.last = (i == n - 1);
            exp_q.push_back(e);
        end
        send_desc(dec, mode, key, iv, seglen, 16'(n));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        exp_t e;
        int   iss0;
        int   t;
        pt[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
        pt[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
        pt[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
        pt[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
        ct[0] = 128'h3b3fd92eb72dad20333449f8e83cfb4a;
        ct[1] = 128'h7789508d16918f03f53c52dac54ed825;
        ct[2] = 128'h9740051e9c5fecf64344f7a82260edcc;
        ct[3] = 128'h304c6528f659c77866a510d9c1d6ae5e;
        for (int i = 0; i < 4; i++) ks_tab[i] = pt[i] ^ ct[i];

        rst = 1'b1;
        desc_valid = 1'b0; desc_decipher = 1'b0; desc_mode = '0; desc_key = '0;
        desc_iv = '0; desc_seglen = '0; desc_nblk = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", 128'({desc_ready, in_ready, out_valid, out_last, err, core_cipher_en,
                                core_decipher_en, core_chain_en}), 128'(0));
        chk("reset_data", out_data | core_data_in | core_key | core_init_vector |
                          128'({core_mode, core_segment_len}), 128'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_desc_ready", 128'(desc_ready), 128'(1));

        // OFB known-answer, cipher then decipher
        for (int i = 0; i < 4; i++) begin
            in_q.push_back(pt[i]);
            e.data = ct[i]; e.last = (i == 3);
            exp_q.push_back(e);
        end
        send_desc(1'b0, 4'd3, NIST_KEY, NIST_IV, 16'd0, 16'd4);
        wait_done();
        for (int i = 0; i < 4; i++) begin
            in_q.push_back(ct[i]);
            e.data = pt[i]; e.last = (i == 3);
            exp_q.push_back(e);
        end
        send_desc(1'b1, 4'd3, NIST_KEY, NIST_IV, 16'd3, 16'd4);
        wait_done();

        repeat (6) begin
            rand_msg(int'($urandom_range(1, 5)));
            wait_done();
        end

        // backpressure on block 2
        bp_en = 1; bp_cnt = 0;
        rand_msg(3);
        wait_done();
        chk("bp_cycles", 128'(bp_cnt), 128'(20));
        bp_en = 0;

        // illegal descriptors
        iss0 = stub_issued;
        send_desc(1'b0, 4'd7, NIST_KEY, NIST_IV, 16'd0, 16'd2);
        send_desc(1'b0, 4'd1, NIST_KEY, NIST_IV, 16'd0, 16'd0);
        repeat (3) @(negedge clk);
        chk("illegal_no_enable", 128'(stub_issued), 128'(iss0));
        chk("illegal_desc_ready", 128'(desc_ready), 128'(1));

        // reset during BUSY of block 2
        stub_lat_fix = 10;
        iss0 = stub_issued;
        rand_msg(3);
        t = 0;
        while (stub_issued < iss0 + 2 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) fail_now("reset_test_issue_wait");
        repeat (2) @(negedge clk);
        chk("pre_reset_busy", 128'({in_ready, out_valid, core_chain_en}), 128'(3'b001));
        rst = 1'b1;
        in_q.delete();
        exp_q.delete();
        @(negedge clk);
        chk("midrst_ctrl", 128'({desc_ready, in_ready, out_valid, out_last, err, core_cipher_en,
                                 core_decipher_en, core_chain_en}), 128'(0));
        chk("midrst_data", out_data | core_data_in | core_key | core_init_vector |
                           128'({core_mode, core_segment_len}), 128'(0));
        rst = 1'b0;
        stub_lat_fix = -1;
        rand_msg(2);
        wait_done();

`ifdef AES_CTRL_TIMEOUT_EN
        stub_dead = 1;
        iss0 = stub_issued;
        in_q.push_back(128'h1);
        send_desc(1'b0, 4'd0, NIST_KEY, NIST_IV, 16'd0, 16'd1);
        t = 0;
        while (stub_issued == iss0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        t = 0;
        while (!err && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!err) fail_now("timeout_err_wait");
        else begin
            chk("timeout_latency", 128'(cyc), 128'(stub_issue_cyc + 17));
            chk("timeout_idle", 128'({desc_ready, core_chain_en}), 128'(2'b10));
        end
        @(negedge clk);
        chk("timeout_err_pulse", 128'(err), 128'(0));
        stub_dead = 0;
        in_q.delete();
`endif

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
